// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: jump request, instruction ROM port and the downstream {pc, instr} handshake.
// The master modport is the fetch stage; the slave side is the ROM plus the consumer.
interface pc_fetch_if;
   localparam int unsigned AW = 16;

   logic          load;
   logic [AW-1:0] jump_addr;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [AW-1:0] rom_data;
   logic          instr_valid;
   logic          instr_ready;
   logic [AW-1:0] instr;
   logic [AW-1:0] instr_pc;

   modport master (
      input  load, jump_addr, rom_data, instr_ready,
      output rom_en, rom_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output load, jump_addr, rom_data, instr_ready,
      input  rom_en, rom_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/pc_fetch.sv
// Hack CPU program counter and fetch stage: drives a 1-cycle synchronous ROM and buffers
// {pc, instr} pairs in a small FIFO so fetches keep flowing under downstream backpressure.
module pc_fetch #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [15:0] RESET_ADDR = 16'h0000
) (
   input logic        clk,
   input logic        reset,
   pc_fetch_if.master bus
);
   localparam int unsigned AW = 16;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [AW-1:0] instr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          inflight;
   logic [AW-1:0] inflight_pc;
   logic [AW-1:0] fetch_pc;

   logic          valid_c;
   logic          pop_c;
   logic          push_c;
   logic          issue_c;
   logic [OW-1:0] occ_c;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + PW'(1));
   endfunction

   // Occupancy after this cycle's pop decides whether another fetch can be launched safely.
   always_comb begin
      valid_c = 1'b0;
      pop_c   = 1'b0;
      push_c  = 1'b0;
      issue_c = 1'b0;
      occ_c   = OW'(count) + OW'(inflight);
      if (!reset && !bus.load) begin
         valid_c = (count != '0);
         pop_c   = valid_c && bus.instr_ready;
         push_c  = inflight;
         occ_c   = occ_c - OW'(pop_c);
         issue_c = (occ_c < OW'(DEPTH));
      end
   end

   assign bus.instr_valid = valid_c;
   assign bus.rom_en      = issue_c;
   assign bus.rom_addr    = fetch_pc;
   assign bus.instr       = mem[rd_ptr].instr;
   assign bus.instr_pc    = mem[rd_ptr].pc;

   // A jump behaves like a partial reset: queued and in-flight fetches are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_ADDR;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i[PW-1:0]] <= '0;
         end
      end else if (bus.load) begin
         fetch_pc <= bus.jump_addr;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue_c;
         if (issue_c) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + AW'(1);
         end
         if (push_c) begin
            mem[wr_ptr] <= '{pc: inflight_pc, instr: bus.rom_data};
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop_c) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push_c && !pop_c) begin
            count <= count + CW'(1);
         end else if (!push_c && pop_c) begin
            count <= count - CW'(1);
         end
      end
   end
endmodule
